// File: rtl/cic_dec_param.sv
// cic_dec_param: N-stage CIC decimator with run-time power-of-two ratio.
//
// The filter runs N integrators at the input rate and N combs at the
// decimated rate. A rounding arithmetic shift removes the R^N DC gain, so a
// constant input x settles to dout = x.
//
// Ports:
//   clki     - sole clock; all state changes on its rising edge
//   rst      - synchronous active-high reset
//   mode     - input format: 0 = signed PCM, 1 = ternary sigma-delta in din[1:0]
//   dec_sel  - decimation select; ratio R = 2^sel, clamped to LOG2_RMAX
//   din      - input sample (IW bits)
//   din_vld  - din is accepted this cycle
//   dout     - signed, normalised decimated sample (OW bits); holds between outputs
//   dout_vld - one-cycle strobe that marks a new dout
//
// Timing: for a decimation event in cycle T, dout_vld is high in cycle T+N+2.
// A change of the effective sel or of mode flushes the filter in the
// following cycle. The first N events after reset or flush only fill the
// comb history and produce no output.

// One comb stage with differential delay 1. The delay and output registers
// advance only when the stage input is valid.
module cic_comb_stage #(
  parameter int BW = 40
) (
  input  logic          clki,
  input  logic          rst,
  input  logic          clr,
  input  logic          in_vld,
  input  logic [BW-1:0] din,
  output logic [BW-1:0] dout
);
  logic [BW-1:0] dly_q, dly_d;
  logic [BW-1:0] out_q, out_d;

  always_comb begin
    dly_d = dly_q;
    out_d = out_q;
    if (clr) begin
      dly_d = '0;
      out_d = '0;
    end else if (in_vld) begin
      out_d = din - dly_q;
      dly_d = din;
    end
  end

  always_ff @(posedge clki) begin
    if (rst) begin
      dly_q <= '0;
      out_q <= '0;
    end else begin
      dly_q <= dly_d;
      out_q <= out_d;
    end
  end

  assign dout = out_q;
endmodule

module cic_dec_param #(
  parameter int N         = 3,
  parameter int IW        = 16,
  parameter int LOG2_RMAX = 8,
  parameter int OW        = 17
) (
  input  logic                             clki,
  input  logic                             rst,
  input  logic                             mode,
  input  logic [$clog2(LOG2_RMAX+1)-1:0]   dec_sel,
  input  logic [IW-1:0]                    din,
  input  logic                             din_vld,
  output logic [OW-1:0]                    dout,
  output logic                             dout_vld
);
  localparam int SW  = $clog2(LOG2_RMAX + 1);
  localparam int BW  = IW + N * LOG2_RMAX;
  localparam int SHW = $clog2(N * LOG2_RMAX + 1);
  localparam int WW  = $clog2(N + 1);
  localparam logic [SW-1:0] SEL_MAX = SW'(LOG2_RMAX);
  localparam logic [WW-1:0] N_W     = WW'(N);

  // Configuration registers and flush request
  logic [SW-1:0] sel_eff;
  logic [SW-1:0] sel_q, sel_d;
  logic          mode_q, mode_d;
  logic          flush_q, flush_d;

  always_comb begin
    sel_eff = (dec_sel > SEL_MAX) ? SEL_MAX : dec_sel;
    sel_d   = sel_eff;
    mode_d  = mode;
    flush_d = (sel_eff != sel_q) || (mode != mode_q);
  end

  // Input mapping. A sample arriving in the flush cycle is dropped.
  logic [BW-1:0] x_ext;
  logic          accept;

  always_comb begin
    x_ext = '0;
    if (!mode_q) begin
      x_ext = BW'($signed(din));
    end else begin
      case (din[1:0])
        2'b11:   x_ext = BW'(1);
        2'b00:   x_ext = '1;
        default: x_ext = '0;
      endcase
    end
    accept = din_vld && !flush_q;
  end

  // Integrators. Each stage adds the freshly updated value of the stage
  // before it, so the last stage already holds this sample's contribution.
  logic [N-1:0][BW-1:0] integ_q, integ_d;

  always_comb begin : integ_c
    logic [BW-1:0] acc;
    acc     = x_ext;
    integ_d = integ_q;
    for (int k = 0; k < N; k++) begin
      acc = integ_q[k] + acc;
      if (accept) integ_d[k] = acc;
    end
    if (flush_q) integ_d = '0;
  end

  // Decimation counter. The terminal count is R-1, built as a bit mask.
  logic [LOG2_RMAX-1:0] cnt_q, cnt_d, cnt_max;
  logic                 evt;
  logic [BW-1:0]        dec_q, dec_d;

  always_comb begin
    for (int i = 0; i < LOG2_RMAX; i++) cnt_max[i] = (SW'(i) < sel_q);
    evt   = accept && (cnt_q == cnt_max);
    cnt_d = cnt_q;
    dec_d = dec_q;
    if (flush_q) begin
      cnt_d = '0;
      dec_d = '0;
    end else if (accept) begin
      cnt_d = evt ? '0 : cnt_q + 1'b1;
      if (evt) dec_d = integ_d[N-1];
    end
  end

  // Valid shift register. Bit 0 marks a new decimated sample and bit k+1
  // marks a new output of comb stage k.
  logic [N:0] vld_pipe_q, vld_pipe_d;

  always_comb begin
    vld_pipe_d = flush_q ? '0 : {vld_pipe_q[N-1:0], evt};
  end

  // Comb chain
  logic [BW-1:0] stg [N+1];
  assign stg[0] = dec_q;

  for (genvar k = 0; k < N; k++) begin : g_comb
    cic_comb_stage #(.BW(BW)) u_comb (
      .clki   (clki),
      .rst    (rst),
      .clr    (flush_q),
      .in_vld (vld_pipe_q[k]),
      .din    (stg[k]),
      .dout   (stg[k+1])
    );
  end

  // Normalisation: round half up, then arithmetic shift by N*sel
  logic [SHW-1:0]       sh;
  logic [BW-1:0]        sum;
  logic signed [BW-1:0] norm;

  always_comb begin
    sh   = SHW'(N) * SHW'(sel_q);
    sum  = stg[N];
    norm = $signed(stg[N]);
    if (sh != '0) begin
      sum  = stg[N] + (BW'(1) << (sh - SHW'(1)));
      norm = $signed(sum) >>> sh;
    end
  end

  // Output stage with warm-up suppression
  logic [WW-1:0] warm_q, warm_d;
  logic [OW-1:0] dout_q, dout_d;
  logic          dout_vld_q, dout_vld_d;

  always_comb begin
    warm_d     = warm_q;
    dout_d     = dout_q;
    dout_vld_d = 1'b0;
    if (flush_q) begin
      warm_d = '0;
    end else if (vld_pipe_q[N]) begin
      if (warm_q < N_W) begin
        warm_d = warm_q + 1'b1;
      end else begin
        dout_d     = OW'(norm);
        dout_vld_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clki) begin
    if (rst) begin
      // Configuration loads without a flush, so the filter starts clean
      sel_q      <= sel_eff;
      mode_q     <= mode;
      flush_q    <= 1'b0;
      integ_q    <= '0;
      cnt_q      <= '0;
      dec_q      <= '0;
      vld_pipe_q <= '0;
      warm_q     <= '0;
      dout_q     <= '0;
      dout_vld_q <= 1'b0;
    end else begin
      sel_q      <= sel_d;
      mode_q     <= mode_d;
      flush_q    <= flush_d;
      integ_q    <= integ_d;
      cnt_q      <= cnt_d;
      dec_q      <= dec_d;
      vld_pipe_q <= vld_pipe_d;
      warm_q     <= warm_d;
      dout_q     <= dout_d;
      dout_vld_q <= dout_vld_d;
    end
  end

  assign dout     = dout_q;
  assign dout_vld = dout_vld_q;
endmodule

// File: tb/tb_cic_dec_param.sv
// Directed testbench for cic_dec_param (N=3, IW=16, LOG2_RMAX=8, OW=17).
// A negedge monitor logs each dout_vld pulse (cycle index, value). Each case
// compares the log against the expected strobe schedule and the settled
// value.
module tb_cic_dec_param;
  localparam int N         = 3;
  localparam int IW        = 16;
  localparam int LOG2_RMAX = 8;
  localparam int OW        = 17;
  localparam int SW        = $clog2(LOG2_RMAX + 1);

  logic          clki = 1'b0;
  logic          rst = 1'b1;
  logic          mode = 1'b0;
  logic [SW-1:0] dec_sel = '0;
  logic [IW-1:0] din = '0;
  logic          din_vld = 1'b0;
  logic [OW-1:0] dout;
  logic          dout_vld;

  int n_chk = 0;
  int n_fail = 0;

  int cyc = 0;
  bit mon_en = 1'b0;
  int pc[$];
  int pv[$];
  int dout_c0 = 0;
  int vld_c0 = 0;

  always #5 clki = ~clki;

  cic_dec_param #(.N(N), .IW(IW), .LOG2_RMAX(LOG2_RMAX), .OW(OW)) dut (
    .clki     (clki),
    .rst      (rst),
    .mode     (mode),
    .dec_sel  (dec_sel),
    .din      (din),
    .din_vld  (din_vld),
    .dout     (dout),
    .dout_vld (dout_vld)
  );

  always @(negedge clki) begin
    if (mon_en) begin
      if (cyc == 0) begin
        dout_c0 = $signed(dout);
        vld_c0  = int'(dout_vld);
      end
      if (dout_vld) begin
        pc.push_back(cyc);
        pv.push_back(int'($signed(dout)));
      end
      cyc++;
    end
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Reset with the configuration already applied. Returns at the start of
  // cycle 0, the first cycle out of reset.
  task automatic start(input logic m, input int sel, input int x);
    @(posedge clki); #1;
    rst = 1'b1; mode = m; dec_sel = SW'(sel); din = IW'(x); din_vld = 1'b1;
    @(posedge clki); #1;
    rst = 1'b0;
    pc.delete(); pv.delete();
    cyc = 0; mon_en = 1'b1;
  endtask

  task automatic drive(input int n, input bit tog, input int chg_at, input int new_sel);
    for (int k = 0; k < n; k++) begin
      din_vld = tog ? (k % 2 == 0) : 1'b1;
      if (k == chg_at) dec_sel = SW'(new_sel);
      @(posedge clki); #1;
    end
    mon_en = 1'b0;
  endtask

  // The (N+1)-th event is the first one with an output, N+2 cycles later.
  task automatic run_case(input string tag, input logic m, input int sel, input int x,
                          input int exp, input bit tog, input int n);
    int r, first, sp, ecnt, bad;
    start(m, sel, x);
    drive(n, tog, -1, 0);
    r     = 1 << ((sel > LOG2_RMAX) ? LOG2_RMAX : sel);
    first = (tog ? 2 * ((N + 1) * r - 1) : (N + 1) * r - 1) + N + 2;
    sp    = tog ? 2 * r : r;
    ecnt  = (first < n) ? (n - 1 - first) / sp + 1 : 0;
    chk({tag, "_cnt"}, pc.size(), ecnt);
    if (pc.size() > 0) begin
      chk({tag, "_first_cyc"}, pc[0], first);
      chk({tag, "_first_val"}, pv[0], exp);
      chk({tag, "_last_val"}, pv[pv.size()-1], exp);
      bad = 0;
      foreach (pc[i]) if (pc[i] != first + i * sp || pv[i] != exp) bad++;
      chk({tag, "_sched"}, bad, 0);
    end
  endtask

  initial begin
    int pre, gap, after_cyc, after_val;
    rst = 1'b1; mode = 1'b0; dec_sel = SW'(2); din = '0; din_vld = 1'b1;
    repeat (3) @(posedge clki);
    @(negedge clki);
    chk("rst_dout", int'($signed(dout)), 0);
    chk("rst_vld", int'(dout_vld), 0);

    run_case("m0_r4",   1'b0, 2,  1000,    1000,   1'b0, 40);
    run_case("m0_r1",   1'b0, 0,  -1234,   -1234,  1'b0, 30);
    run_case("m1_pos",  1'b1, 3,  'hABC3,  1,      1'b0, 100);
    run_case("m1_zero", 1'b1, 3,  'h5551,  0,      1'b0, 100);
    run_case("m1_neg",  1'b1, 3,  'hFFFC,  -1,     1'b0, 100);
    run_case("m0_min",  1'b0, 8,  -32768,  -32768, 1'b0, 1300);
    run_case("m0_max",  1'b0, 8,  32767,   32767,  1'b0, 1300);
    run_case("clamp",   1'b0, 12, 100,     100,    1'b0, 1100);
    run_case("toggle",  1'b0, 1,  -5,      -5,     1'b1, 40);

    // Reset while an event is still in the comb pipeline
    run_case("pre_rst",  1'b0, 2, 1000, 1000, 1'b0, 26);
    run_case("post_rst", 1'b0, 2, 1000, 1000, 1'b0, 40);
    chk("post_rst_dout0", dout_c0, 0);
    chk("post_rst_vld0", vld_c0, 0);

    // sel 2 -> 4 in cycle 42: flush in 43, counting resumes in 44, and the
    // 4th event at R=16 (cycle 107) gives the first new strobe at 112.
    start(1'b0, 2, 300);
    drive(150, 1'b0, 42, 4);
    pre = 0; gap = 0; after_cyc = -1; after_val = 0;
    foreach (pc[i]) begin
      if (pc[i] <= 41) pre++;
      else if (pc[i] < 112) gap++;
      else if (after_cyc < 0) begin
        after_cyc = pc[i];
        after_val = pv[i];
      end
    end
    chk("chg_pre_cnt", pre, 6);
    chk("chg_gap_cnt", gap, 0);
    chk("chg_first_cyc", after_cyc, 112);
    chk("chg_first_val", after_val, 300);
    chk("chg_total", pc.size(), 9);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
